// File: rtl/axi_stream_dw_pkg.sv
// Shared helpers for the AXI-Stream data-width converters (upsizer and downsizer).
package axi_stream_dw_pkg;

  function automatic int unsigned ratio(input int unsigned data_width_in,
                                        input int unsigned data_width_out);
    return (data_width_in == 0) ? 0 : data_width_out / data_width_in;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  // Optional sideband fields of width 0 still get a 1-bit port, tied to zero.
  function automatic int unsigned port_width(input int unsigned w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/axi_stream_bus.sv
// AXI-Stream bundle used by the interface-style wrappers of the width converters.
interface AXI_STREAM_BUS
  import axi_stream_dw_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned IdWidth   = 0,
  parameter int unsigned DestWidth = 0,
  parameter int unsigned UserWidth = 0
);
  logic                               tvalid;
  logic                               tready;
  logic [DataWidth-1:0]               tdata;
  logic [DataWidth/8-1:0]             tstrb;
  logic [DataWidth/8-1:0]             tkeep;
  logic                               tlast;
  logic [port_width(IdWidth)-1:0]     tid;
  logic [port_width(DestWidth)-1:0]   tdest;
  logic [port_width(UserWidth)-1:0]   tuser;

  modport Master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
  modport Slave  (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi_stream_dw_upsizer_intf.sv
// Interface-port wrapper: binds AXI_STREAM_BUS in/out bundles to the flat upsizer.
module axi_stream_dw_upsizer_intf
  import axi_stream_dw_pkg::*;
#(
  parameter int unsigned DataWidthIn  = 8,
  parameter int unsigned DataWidthOut = 32,
  parameter int unsigned IdWidth      = 0,
  parameter int unsigned DestWidth    = 0,
  parameter int unsigned UserWidth    = 0
) (
  input logic         clk_i,
  input logic         rst_ni,
  AXI_STREAM_BUS.Slave  in_bus,
  AXI_STREAM_BUS.Master out_bus
);

  axi_stream_dw_upsizer #(
    .DataWidthIn (DataWidthIn),
    .DataWidthOut(DataWidthOut),
    .IdWidth     (IdWidth),
    .DestWidth   (DestWidth),
    .UserWidth   (UserWidth)
  ) i_upsizer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_tvalid (in_bus.tvalid),
    .in_tready (in_bus.tready),
    .in_tdata  (in_bus.tdata),
    .in_tstrb  (in_bus.tstrb),
    .in_tkeep  (in_bus.tkeep),
    .in_tlast  (in_bus.tlast),
    .in_tid    (in_bus.tid),
    .in_tdest  (in_bus.tdest),
    .in_tuser  (in_bus.tuser),
    .out_tvalid(out_bus.tvalid),
    .out_tready(out_bus.tready),
    .out_tdata (out_bus.tdata),
    .out_tstrb (out_bus.tstrb),
    .out_tkeep (out_bus.tkeep),
    .out_tlast (out_bus.tlast),
    .out_tid   (out_bus.tid),
    .out_tdest (out_bus.tdest),
    .out_tuser (out_bus.tuser)
  );

endmodule

// File: rtl/axi_stream_dw_upsizer.sv
// Packs Ratio consecutive narrow AXI-Stream beats (little-endian) into one wide beat.
// A tlast before the final lane closes the word early with the unused lanes zeroed.
module axi_stream_dw_upsizer
  import axi_stream_dw_pkg::*;
#(
  parameter int unsigned DataWidthIn  = 8,
  parameter int unsigned DataWidthOut = 32,
  parameter int unsigned IdWidth      = 0,
  parameter int unsigned DestWidth    = 0,
  parameter int unsigned UserWidth    = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              in_tvalid,
  output logic                              in_tready,
  input  logic [DataWidthIn-1:0]            in_tdata,
  input  logic [DataWidthIn/8-1:0]          in_tstrb,
  input  logic [DataWidthIn/8-1:0]          in_tkeep,
  input  logic                              in_tlast,
  input  logic [port_width(IdWidth)-1:0]    in_tid,
  input  logic [port_width(DestWidth)-1:0]  in_tdest,
  input  logic [port_width(UserWidth)-1:0]  in_tuser,
  output logic                              out_tvalid,
  input  logic                              out_tready,
  output logic [DataWidthOut-1:0]           out_tdata,
  output logic [DataWidthOut/8-1:0]         out_tstrb,
  output logic [DataWidthOut/8-1:0]         out_tkeep,
  output logic                              out_tlast,
  output logic [port_width(IdWidth)-1:0]    out_tid,
  output logic [port_width(DestWidth)-1:0]  out_tdest,
  output logic [port_width(UserWidth)-1:0]  out_tuser
);

  localparam int unsigned Ratio    = ratio(DataWidthIn, DataWidthOut);
  localparam int unsigned CntWidth = cnt_width(Ratio);
  localparam int unsigned StrbIn   = DataWidthIn / 8;
  localparam int unsigned IdW      = port_width(IdWidth);
  localparam int unsigned DestW    = port_width(DestWidth);
  localparam int unsigned UserW    = port_width(UserWidth);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(Ratio - 1);

  if (DataWidthIn == 0 || (DataWidthIn % 8) != 0 || (DataWidthOut % DataWidthIn) != 0 ||
      Ratio < 2) begin : g_bad_width
    $fatal(1, "axi_stream_dw_upsizer: DataWidthOut must be a multiple >= 2 of DataWidthIn (a multiple of 8)");
  end

  typedef struct packed {
    logic [DataWidthIn-1:0] data;
    logic [StrbIn-1:0]      strb;
    logic [StrbIn-1:0]      keep;
  } lane_t;

  typedef struct packed {
    logic [Ratio-1:0][DataWidthIn-1:0] data;
    logic [Ratio-1:0][StrbIn-1:0]      strb;
    logic [Ratio-1:0][StrbIn-1:0]      keep;
    logic                              last;
    logic [IdW-1:0]                    id;
    logic [DestW-1:0]                  dest;
    logic [UserW-1:0]                  user;
  } beat_t;

  logic [CntWidth-1:0]   cnt_q, cnt_d;
  lane_t [Ratio-2:0]     acc_q;
  logic [IdW-1:0]        first_id_q;
  logic [DestW-1:0]      first_dest_q;
  beat_t                 out_q, out_d;
  logic                  out_valid_q, out_valid_d;

  lane_t                 cur_lane;
  lane_t [Ratio-1:0]     word_lanes;
  logic [IdW-1:0]        in_id;
  logic [DestW-1:0]      in_dest;
  logic [UserW-1:0]      in_user;
  logic                  in_hs;
  logic                  completing;

  // Absent sideband fields are forced to zero so they can never leak to the output.
  assign in_id   = (IdWidth   > 0) ? in_tid   : '0;
  assign in_dest = (DestWidth > 0) ? in_tdest : '0;
  assign in_user = (UserWidth > 0) ? in_tuser : '0;

  assign cur_lane.data = in_tdata;
  assign cur_lane.strb = in_tstrb;
  assign cur_lane.keep = in_tkeep;

  assign in_tready  = !out_valid_q || out_tready;
  assign in_hs      = in_tvalid && in_tready;
  assign completing = in_hs && (in_tlast || cnt_q == CntLast);

  // Lanes below cnt come from the accumulator, lane cnt is the current beat, the rest are zero.
  for (genvar i = 0; i < Ratio; i++) begin : g_lane
    localparam logic [CntWidth-1:0] LaneIdx = CntWidth'(i);
    if (i < Ratio - 1) begin : g_acc
      assign word_lanes[i] = (cnt_q > LaneIdx)  ? acc_q[i] :
                             (cnt_q == LaneIdx) ? cur_lane : '0;
    end else begin : g_top
      assign word_lanes[i] = (cnt_q == LaneIdx) ? cur_lane : '0;
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (out_valid_q && out_tready) out_valid_d = 1'b0;
    if (in_hs) begin
      if (completing) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        for (int i = 0; i < Ratio; i++) begin
          out_d.data[i] = word_lanes[i].data;
          out_d.strb[i] = word_lanes[i].strb;
          out_d.keep[i] = word_lanes[i].keep;
        end
        out_d.last = in_tlast;
        out_d.id   = (cnt_q == '0) ? in_id   : first_id_q;
        out_d.dest = (cnt_q == '0) ? in_dest : first_dest_q;
        out_d.user = in_user;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  // NOTE: lane storage has no reset; lanes at or above cnt are masked off when the word is built.
  always_ff @(posedge clk_i) begin
    if (in_hs && !completing) acc_q[cnt_q] <= cur_lane;
    if (in_hs && cnt_q == '0) begin
      first_id_q   <= in_id;
      first_dest_q <= in_dest;
    end
  end

  assign out_tvalid = out_valid_q;
  assign out_tdata  = out_q.data;
  assign out_tstrb  = out_q.strb;
  assign out_tkeep  = out_q.keep;
  assign out_tlast  = out_q.last;
  assign out_tid    = out_q.id;
  assign out_tdest  = out_q.dest;
  assign out_tuser  = out_q.user;

`ifndef SYNTHESIS
  // tid/tdest must stay constant across the beats of one wide word.
  sideband_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (in_hs && cnt_q != '0) |-> (in_id == first_id_q && in_dest == first_dest_q))
    else $error("axi_stream_dw_upsizer: tid/tdest changed within a wide word");
`endif

endmodule

// File: tb/tb_axi_stream_dw_upsizer.sv
// Bench for the 8->32 upsizer: directed scenarios plus a randomized downsizer round trip.
module tb_axi_stream_dw_upsizer;

  localparam int unsigned Timeout = 2000;
  localparam int unsigned NWords  = 200;

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic [31:0] data;
  } wide_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_tvalid, in_tready;
  logic [7:0]  in_tdata;
  logic [0:0]  in_tstrb, in_tkeep;
  logic        in_tlast;
  logic [0:0]  in_tid, in_tdest, in_tuser;
  logic        out_tvalid, out_tready;
  logic [31:0] out_tdata;
  logic [3:0]  out_tstrb, out_tkeep;
  logic        out_tlast;
  logic [0:0]  out_tid, out_tdest, out_tuser;

  int n_vec = 0;
  int n_err = 0;

  wide_t got_q[$];
  wide_t exp_q[$];
  bit    mon_en = 1'b0;

  always #5 clk_i = ~clk_i;

  axi_stream_dw_upsizer #(
    .DataWidthIn (8),
    .DataWidthOut(32),
    .IdWidth     (0),
    .DestWidth   (0),
    .UserWidth   (0)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tdata  (in_tdata),
    .in_tstrb  (in_tstrb),
    .in_tkeep  (in_tkeep),
    .in_tlast  (in_tlast),
    .in_tid    (in_tid),
    .in_tdest  (in_tdest),
    .in_tuser  (in_tuser),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tdata (out_tdata),
    .out_tstrb (out_tstrb),
    .out_tkeep (out_tkeep),
    .out_tlast (out_tlast),
    .out_tid   (out_tid),
    .out_tdest (out_tdest),
    .out_tuser (out_tuser)
  );

  // Output handshakes are recorded mid-cycle, when valid/ready are stable for the next edge.
  always @(negedge clk_i) begin
    if (mon_en && rst_ni && out_tvalid && out_tready)
      got_q.push_back({out_tlast, out_tkeep, out_tstrb, out_tdata});
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one narrow beat and returns one cycle-slot after the edge that accepted it.
  task automatic send_beat(input logic [7:0] d, input logic l, output int waited);
    bit hs;
    hs        = 1'b0;
    waited    = 0;
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tstrb  = 1'b1;
    in_tkeep  = 1'b1;
    in_tlast  = l;
    while (!hs) begin
      @(negedge clk_i);
      hs = in_tready;
      @(posedge clk_i);
      #1;
      if (!hs) begin
        waited++;
        if (waited > Timeout) begin
          n_vec++;
          n_err++;
          $display("FAIL send_beat_timeout beat=%h waited=%0d cycles, expected acceptance within %0d", d, waited, Timeout);
          hs = 1'b1;
        end
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic check_word(input string name, input logic [31:0] data, input logic [3:0] keep,
                            input logic last);
    n_vec++;
    if (out_tvalid !== 1'b1 || out_tdata !== data || out_tkeep !== keep ||
        out_tstrb !== keep || out_tlast !== last) begin
      n_err++;
      $display("FAIL %s got valid=%b data=%h keep=%h strb=%h last=%b, expected valid=1 data=%h keep=%h strb=%h last=%b",
               name, out_tvalid, out_tdata, out_tkeep, out_tstrb, out_tlast, data, keep, keep, last);
    end
  endtask

  task automatic test_reset();
    rst_ni     = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    in_tstrb   = '0;
    in_tkeep   = '0;
    in_tlast   = 1'b0;
    in_tid     = '0;
    in_tdest   = '0;
    in_tuser   = '0;
    out_tready = 1'b1;
    #23;
    n_vec++;
    if (out_tvalid !== 1'b0 || out_tdata !== 32'h0 || out_tkeep !== 4'h0 || out_tstrb !== 4'h0 ||
        out_tlast !== 1'b0 || out_tid !== 1'b0 || out_tdest !== 1'b0 || out_tuser !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs got valid=%b data=%h keep=%h strb=%h last=%b, expected all zero",
               out_tvalid, out_tdata, out_tkeep, out_tstrb, out_tlast);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle();
    n_vec++;
    if (in_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_tready got=%b expected=1", in_tready);
    end
  endtask

  task automatic test_single_word();
    int w;
    int total;
    logic [7:0] beats [4];
    beats = '{8'hef, 8'h56, 8'h34, 8'h12};
    total = 0;
    out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(beats[i], i == 3, w);
      total += w;
    end
    check_word("single_word", 32'h123456ef, 4'hf, 1'b1);
    cycle();
    n_vec++;
    if (out_tvalid !== 1'b0 || total != 0) begin
      n_err++;
      $display("FAIL single_word_pulse got valid=%b stalls=%0d, expected valid=0 stalls=0", out_tvalid, total);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int total;
    logic [7:0] beats [4];
    beats = '{8'hef, 8'h56, 8'h34, 8'h12};
    total = 0;
    out_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat(beats[i % 4], i == 7, w);
      total += w;
      if (i == 3) check_word("b2b_word0", 32'h123456ef, 4'hf, 1'b0);
      if (i == 4) begin
        n_vec++;
        if (out_tvalid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_drain got valid=%b expected=0", out_tvalid);
        end
      end
    end
    check_word("b2b_word1", 32'h123456ef, 4'hf, 1'b1);
    n_vec++;
    if (total != 0) begin
      n_err++;
      $display("FAIL b2b_in_tready stalls=%0d expected=0", total);
    end
    cycle();
  endtask

  task automatic test_partial();
    int w;
    out_tready = 1'b1;
    send_beat(8'hef, 1'b0, w);
    send_beat(8'h56, 1'b1, w);
    check_word("partial", 32'h000056ef, 4'h3, 1'b1);
    cycle();
  endtask

  task automatic test_backpressure();
    int w;
    logic [7:0] beats [4];
    beats = '{8'hef, 8'h56, 8'h34, 8'h12};
    out_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(beats[i], i == 3, w);
    in_tvalid = 1'b1;
    in_tdata  = 8'haa;
    in_tstrb  = 1'b1;
    in_tkeep  = 1'b1;
    in_tlast  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      n_vec++;
      if (in_tready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_in_tready cycle=%0d got=%b expected=0", k, in_tready);
      end
      check_word("bp_hold", 32'h123456ef, 4'hf, 1'b1);
      cycle();
    end
    out_tready = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if (in_tready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready got=%b expected=1", in_tready);
    end
    cycle();
    in_tvalid = 1'b0;
    n_vec++;
    if (out_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release_valid got=%b expected=0", out_tvalid);
    end
    send_beat(8'hbb, 1'b0, w);
    send_beat(8'hcc, 1'b0, w);
    send_beat(8'hdd, 1'b1, w);
    check_word("bp_next_word", 32'hddccbbaa, 4'hf, 1'b1);
    cycle();
  endtask

  task automatic test_reset_midword();
    int w;
    logic [7:0] beats [4];
    beats = '{8'hef, 8'h56, 8'h34, 8'h12};
    out_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'h90 + 8'(i), i == 3, w);
    #2;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (out_tvalid !== 1'b0 || out_tdata !== 32'h0 || out_tkeep !== 4'h0) begin
      n_err++;
      $display("FAIL async_reset got valid=%b data=%h keep=%h, expected valid=0 data=0 keep=0",
               out_tvalid, out_tdata, out_tkeep);
    end
    @(negedge clk_i);
    rst_ni     = 1'b1;
    out_tready = 1'b1;
    cycle();
    send_beat(8'haa, 1'b0, w);
    send_beat(8'hbb, 1'b0, w);
    #2;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) send_beat(beats[i], i == 3, w);
    check_word("reset_midword", 32'h123456ef, 4'hf, 1'b1);
    cycle();
  endtask

  // Model: a 32->8 downsizer splits each word into four little-endian bytes with tlast on the
  // last byte; the upsizer must reassemble exactly the original words.
  task automatic test_random();
    bit src_done;
    int budget;
    src_done = 1'b0;
    budget   = 0;
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < NWords; n++) begin
      wide_t e;
      e.data = $urandom;
      e.last = ($urandom_range(3, 0) == 0);
      e.keep = 4'hf;
      e.strb = 4'hf;
      exp_q.push_back(e);
    end
    mon_en = 1'b1;
    fork
      begin
        int w;
        for (int n = 0; n < NWords; n++) begin
          for (int b = 0; b < 4; b++) begin
            int gap;
            gap = ($urandom_range(7, 0) == 0) ? $urandom_range(50, 0) : 0;
            repeat (gap) cycle();
            send_beat(exp_q[n].data[b*8 +: 8], exp_q[n].last && b == 3, w);
          end
        end
        src_done = 1'b1;
      end
      begin
        while ((!src_done || got_q.size() < NWords) && budget < 60000) begin
          int hold;
          out_tready = 1'($urandom_range(1, 0));
          hold = ($urandom_range(7, 0) == 0) ? $urandom_range(50, 0) : $urandom_range(3, 0);
          for (int h = 0; h <= hold; h++) begin
            cycle();
            budget++;
          end
        end
        out_tready = 1'b1;
      end
    join
    repeat (3) cycle();
    mon_en = 1'b0;
    n_vec++;
    if (got_q.size() != NWords) begin
      n_err++;
      $display("FAIL random_count got=%0d words expected=%0d", got_q.size(), NWords);
    end
    for (int n = 0; n < NWords && n < got_q.size(); n++) begin
      n_vec++;
      if (got_q[n] !== exp_q[n]) begin
        n_err++;
        $display("FAIL random_word[%0d] got data=%h keep=%h strb=%h last=%b expected data=%h keep=%h strb=%h last=%b",
                 n, got_q[n].data, got_q[n].keep, got_q[n].strb, got_q[n].last,
                 exp_q[n].data, exp_q[n].keep, exp_q[n].strb, exp_q[n].last);
      end
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial();
    test_backpressure();
    test_reset_midword();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
